// File: rtl/jtframe_sdram_resp.sv
// jtframe_sdram_resp
//   Single-request SDRAM responder. It answers one slot-arbiter request at a
//   time and serves it from an internal 2^AW x 16-bit word memory. It drives
//   the controller side of the sdram_rd/sdram_wr handshake with fixed timing.
//   An optional periodic refresh window makes the block busy between
//   transactions.
//
// Ports
//   clk           in   clock; all logic is on the rising edge
//   rst_n         in   asynchronous active-low reset
//   sdram_rd      in   read request (level, held until ack)
//   sdram_wr      in   write request (level, held until ack); wins over rd
//   sdram_addr    in   word address; only [AW-1:0] is used
//   data_write    in   write data
//   sdram_wrmask  in   byte write mask, active low; bit 1 covers [15:8]
//   sdram_ack     out  one-cycle acceptance pulse, cycle after capture
//   data_dst      out  one-cycle pulse, one cycle before data_rdy
//   data_rdy      out  one-cycle completion pulse; data_read is valid
//   data_read     out  addressed word (post-write on writes), held
//   busy          out  high whenever the FSM is not idle
module jtframe_sdram_resp #(
  parameter int SDRAMW     = 22,
  parameter int AW         = 12,
  parameter int LATENCY    = 4,
  parameter int REF_PERIOD = 0,
  parameter int REF_LEN    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sdram_rd,
  input  logic              sdram_wr,
  input  logic [SDRAMW-1:0] sdram_addr,
  input  logic [15:0]       data_write,
  input  logic [1:0]        sdram_wrmask,
  output logic              sdram_ack,
  output logic              data_dst,
  output logic              data_rdy,
  output logic [15:0]       data_read,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, ACK, WAIT, DST, RDY, REF} state_t;

  // ACK and DST take one cycle each, so WAIT covers the other LATENCY-2.
  localparam logic [3:0]  WAIT_LOAD = (LATENCY > 2) ? 4'(LATENCY - 3) : 4'd0;
  localparam logic [3:0]  REF_LOAD  = 4'(REF_LEN - 1);
  localparam bit          REF_EN    = (REF_PERIOD > 0);
  localparam logic [31:0] REF_LAST  = (REF_PERIOD > 0) ? 32'(REF_PERIOD - 1) : 32'd0;

  state_t         state_q, state_d;
  logic [3:0]     wcnt_q, wcnt_d;
  logic [31:0]    ref_cnt_q, ref_cnt_d;
  logic           ref_pend_q, ref_pend_d;
  logic [15:0]    data_read_q, data_read_d;

  logic [AW-1:0]  addr_q, addr_d;
  logic [15:0]    wdata_q, wdata_d;
  logic [1:0]     mask_q, mask_d;
  logic           wr_q, wr_d;

  logic           cap;
  logic           mem_we;
  logic           ref_wrap;
  logic [15:0]    mem_rd;
  logic [15:0]    mem [2**AW];

  // The address bits above AW are ignored on purpose; this only keeps them
  // referenced.
  logic           unused_addr;
  assign unused_addr = ^sdram_addr;

  assign mem_rd = mem[addr_q];

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    ref_cnt_d   = ref_cnt_q;
    ref_pend_d  = ref_pend_q;
    data_read_d = data_read_q;
    cap         = 1'b0;
    mem_we      = 1'b0;
    ref_wrap    = REF_EN && (ref_cnt_q == REF_LAST);

    if (REF_EN) begin
      ref_cnt_d = ref_wrap ? 32'd0 : ref_cnt_q + 32'd1;
    end

    case (state_q)
      IDLE: begin
        // A due refresh goes ahead of a waiting request.
        if (ref_pend_q) begin
          state_d    = REF;
          wcnt_d     = REF_LOAD;
          ref_pend_d = 1'b0;
        end else if (sdram_rd || sdram_wr) begin
          state_d = ACK;
          cap     = 1'b1;
        end
      end
      ACK: begin
        mem_we = wr_q;
        if (LATENCY > 2) begin
          state_d = WAIT;
          wcnt_d  = WAIT_LOAD;
        end else begin
          state_d = DST;
        end
      end
      WAIT: begin
        if (wcnt_q == 4'd0) state_d = DST;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      DST: begin
        // The write landed at the end of ACK, so this is the post-write word.
        state_d     = RDY;
        data_read_d = mem_rd;
      end
      RDY: state_d = IDLE;
      REF: begin
        if (wcnt_q == 4'd0) state_d = IDLE;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase

    // A new wrap on the cycle refresh starts re-arms it.
    if (ref_wrap) ref_pend_d = 1'b1;
  end

  always_comb begin
    addr_d  = cap ? sdram_addr[AW-1:0] : addr_q;
    wdata_d = cap ? data_write         : wdata_q;
    mask_d  = cap ? sdram_wrmask       : mask_q;
    wr_d    = cap ? sdram_wr           : wr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wcnt_q      <= 4'd0;
      ref_cnt_q   <= 32'd0;
      ref_pend_q  <= 1'b0;
      data_read_q <= 16'h0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      ref_cnt_q   <= ref_cnt_d;
      ref_pend_q  <= ref_pend_d;
      data_read_q <= data_read_d;
    end
  end

  // Captured request fields are only consumed after a capture, so no reset.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    mask_q  <= mask_d;
    wr_q    <= wr_d;
  end

  // Word memory survives reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (!mask_q[0]) mem[addr_q][7:0]  <= wdata_q[7:0];
      if (!mask_q[1]) mem[addr_q][15:8] <= wdata_q[15:8];
    end
  end

  assign sdram_ack = (state_q == ACK);
  assign data_dst  = (state_q == DST);
  assign data_rdy  = (state_q == RDY);
  assign busy      = (state_q != IDLE);
  assign data_read = data_read_q;

endmodule

// File: tb/tb_jtframe_sdram_resp.sv
// Directed bench for jtframe_sdram_resp: u_dut runs without refresh, and
// u_ref runs with REF_PERIOD=20 and REF_LEN=3.
module tb_jtframe_sdram_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        rd = 1'b0, wr = 1'b0;
  logic [21:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [1:0]  mask = 2'b11;
  logic        ack, dst, rdy, busy;
  logic [15:0] rdata;

  logic        r_rd = 1'b0, r_wr = 1'b0;
  logic [21:0] r_addr = '0;
  logic [15:0] r_wdata = '0;
  logic [1:0]  r_mask = 2'b11;
  logic        r_ack, r_dst, r_rdy, r_busy;
  logic [15:0] r_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  jtframe_sdram_resp #(.SDRAMW(22), .AW(12), .LATENCY(4), .REF_PERIOD(0), .REF_LEN(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .sdram_rd(rd), .sdram_wr(wr), .sdram_addr(addr),
    .data_write(wdata), .sdram_wrmask(mask), .sdram_ack(ack), .data_dst(dst),
    .data_rdy(rdy), .data_read(rdata), .busy(busy));

  jtframe_sdram_resp #(.SDRAMW(22), .AW(12), .LATENCY(4), .REF_PERIOD(20), .REF_LEN(3)) u_ref (
    .clk(clk), .rst_n(rst_n), .sdram_rd(r_rd), .sdram_wr(r_wr), .sdram_addr(r_addr),
    .data_write(r_wdata), .sdram_wrmask(r_mask), .sdram_ack(r_ack), .data_dst(r_dst),
    .data_rdy(r_rdy), .data_read(r_rdata), .busy(r_busy));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction on u_dut; the FSM must be idle on entry.
  task automatic xact(input string tag, input logic is_wr, input logic also_rd,
                      input logic [21:0] a, input logic [15:0] d,
                      input logic [1:0] m, input logic [15:0] exp);
    rd = !is_wr || also_rd; wr = is_wr; addr = a; wdata = d; mask = m;
    tick();                                   // T+1
    chk({tag, ".ack"}, ack, 1);
    chk({tag, ".ack_nodst"}, dst, 0);
    rd = 1'b0; wr = 1'b0; addr = '0; wdata = 16'h0; mask = 2'b11;
    tick();                                   // T+2
    chk({tag, ".w1_busy"}, busy, 1);
    chk({tag, ".w1_noack"}, ack, 0);
    tick();                                   // T+3
    chk({tag, ".w2_nodst"}, dst, 0);
    tick();                                   // T+4
    chk({tag, ".dst"}, dst, 1);
    chk({tag, ".dst_nordy"}, rdy, 0);
    tick();                                   // T+5
    chk({tag, ".rdy"}, rdy, 1);
    chk({tag, ".rdy_nodst"}, dst, 0);
    chk({tag, ".data"}, rdata, exp);
    tick();                                   // T+6
    chk({tag, ".idle"}, busy, 0);
    chk({tag, ".rdy_off"}, rdy, 0);
    chk({tag, ".data_hold"}, rdata, exp);
  endtask

  initial begin
    int n_ack, n_rdy, first, second, n_rst_rdy;

    // Reset values while rst_n is low
    tick(); tick();
    chk("rst.ack", ack, 0);
    chk("rst.dst", dst, 0);
    chk("rst.rdy", rdy, 0);
    chk("rst.busy", busy, 0);
    chk("rst.data", rdata, 16'h0);
    chk("rst.ref_busy", r_busy, 0);
    rst_n = 1'b1;
    tick();

    // Write/read, byte masks, wrap, rd+wr together
    xact("wr_beef",  1'b1, 1'b0, 22'h000010, 16'hBEEF, 2'b00, 16'hBEEF);
    xact("rd_beef",  1'b0, 1'b0, 22'h000010, 16'h0000, 2'b11, 16'hBEEF);
    xact("wr_m10",   1'b1, 1'b0, 22'h000010, 16'h1234, 2'b10, 16'hBE34);
    xact("rd_m10",   1'b0, 1'b0, 22'h000010, 16'h0000, 2'b11, 16'hBE34);
    xact("wr_m11",   1'b1, 1'b0, 22'h000010, 16'hFFFF, 2'b11, 16'hBE34);
    xact("wr_wrap",  1'b1, 1'b0, 22'h001005, 16'h5A5A, 2'b00, 16'h5A5A);
    xact("rd_wrap",  1'b0, 1'b0, 22'h000005, 16'h0000, 2'b11, 16'h5A5A);
    xact("wr_both",  1'b1, 1'b1, 22'h000020, 16'h0C0C, 2'b00, 16'h0C0C);
    xact("rd_both",  1'b0, 1'b0, 22'h000020, 16'h0000, 2'b11, 16'h0C0C);

    // Held request, then a new request raised on the rdy cycle
    n_ack = 0; n_rdy = 0; first = -1; second = -1;
    rd = 1'b1; addr = 22'h000010;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (ack) begin
        n_ack++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
      if (first >= 0 && i == first + 1) rd = 1'b0;
      if (i == 6) chk("held.one_ack", n_ack, 1);
      if (rdy) begin
        n_rdy++;
        chk("held.data", rdata, (n_rdy == 1) ? 16'hBE34 : 16'h0C0C);
        if (n_rdy == 1) begin rd = 1'b1; addr = 22'h000020; end
      end
      if (second >= 0 && i == second) rd = 1'b0;
    end
    chk("held.n_ack", n_ack, 2);
    chk("held.n_rdy", n_rdy, 2);
    chk("held.spacing", second - first, 6);

    // Asynchronous reset between ack and data_rdy
    rd = 1'b1; addr = 22'h000005;
    tick();
    chk("arst.ack", ack, 1);
    rd = 1'b0;
    tick();
    chk("arst.busy_pre", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.busy", busy, 0);
    chk("arst.ack0", ack, 0);
    chk("arst.dst0", dst, 0);
    chk("arst.rdy0", rdy, 0);
    chk("arst.data0", rdata, 16'h0);
    n_rst_rdy = 0;
    repeat (6) begin
      tick();
      if (rdy) n_rst_rdy++;
    end
    chk("arst.no_rdy", n_rst_rdy, 0);
    rst_n = 1'b1;
    tick();
    xact("arst_rd", 1'b0, 1'b0, 22'h000010, 16'h0000, 2'b11, 16'hBE34);

    // Refresh timing on u_ref, counted in edges since reset release
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("ref.idle20", r_busy, 0);
    r_wr = 1'b1; r_addr = 22'h000033; r_wdata = 16'hA5C3; r_mask = 2'b00;
    tick();                                   // edge 21: refresh wins
    chk("ref.a_busy1", r_busy, 1);
    chk("ref.a_noack1", r_ack, 0);
    tick();
    chk("ref.a_busy2", r_busy, 1);
    chk("ref.a_noack2", r_ack, 0);
    tick();
    chk("ref.a_busy3", r_busy, 1);
    chk("ref.a_noack3", r_ack, 0);
    tick();                                   // edge 24: back to idle
    chk("ref.a_idle", r_busy, 0);
    tick();                                   // edge 25: request accepted
    chk("ref.a_ack", r_ack, 1);
    r_wr = 1'b0; r_mask = 2'b11;
    repeat (4) tick();                        // edge 29
    chk("ref.a_rdy", r_rdy, 1);
    chk("ref.a_data", r_rdata, 16'hA5C3);
    repeat (7) tick();                        // edge 36
    r_rd = 1'b1; r_addr = 22'h000033;
    tick();                                   // edge 37
    chk("ref.b_ack", r_ack, 1);
    r_rd = 1'b0;
    repeat (3) tick();                        // edge 40: refresh falls due
    chk("ref.b_dst", r_dst, 1);
    tick();
    chk("ref.b_rdy", r_rdy, 1);
    chk("ref.b_data", r_rdata, 16'hA5C3);
    tick();
    chk("ref.b_idle", r_busy, 0);
    tick();                                   // edge 43: refresh starts
    chk("ref.b_ref", r_busy, 1);
    chk("ref.b_noack", r_ack, 0);
    repeat (2) tick();
    chk("ref.b_ref3", r_busy, 1);
    tick();
    chk("ref.b_done", r_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jtframe_sdram_resp.md
JTFRAME_SDRAM_RESP -- requirements
Module: jtframe_sdram_resp

Interface
REQ-001 The block SHALL be a responder that answers one request at a time from a slot arbiter, driving the controller side of the sdram_rd/sdram_wr handshake from an internal word memory.
REQ-002 Parameter SDRAMW, default 22: request address width.
REQ-003 Parameter AW, default 12: internal memory depth of 2^AW 16-bit words; only sdram_addr[AW-1:0] is used.
REQ-004 Parameter LATENCY, default 4, legal 2..15: cycles from request capture to data_dst.
REQ-005 Parameter REF_PERIOD, default 0: cycles between refresh windows; 0 disables refresh.
REQ-006 Parameter REF_LEN, default 3, legal 1..15: busy cycles per refresh window.
REQ-007 Reset is asynchronous and active-low; one clock.
REQ-008 Port: clk  input  1  clock, all logic on rising edge.
REQ-009 Port: rst_n  input  1  asynchronous active-low reset.
REQ-010 Port: sdram_rd  input  1  read request, level, held until ack.
REQ-011 Port: sdram_wr  input  1  write request, level, held until ack.
REQ-012 Port: sdram_addr  input  SDRAMW  word address.
REQ-013 Port: data_write  input  16  write data.
REQ-014 Port: sdram_wrmask  input  2  byte write mask, each bit active low; bit 1 = [15:8].
REQ-015 Port: sdram_ack  output  1  one-cycle request acceptance pulse.
REQ-016 Port: data_dst  output  1  one-cycle pulse, one cycle before data_rdy.
REQ-017 Port: data_rdy  output  1  one-cycle completion pulse; data_read valid.
REQ-018 Port: data_read  output  16  read data.
REQ-019 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-020 FSM states SHALL be IDLE, ACK, WAIT, DST, RDY, REF.
REQ-021 In IDLE with (sdram_rd|sdram_wr) high and no refresh pending, at edge T the block SHALL capture addr, data, mask and the operation type, and enter ACK. sdram_ack is high for the cycle after T.
REQ-022 Both rd and wr high in the same cycle SHALL be treated as a write.
REQ-023 A write SHALL update memory during ACK, byte lane n written only when sdram_wrmask[n]==0; mask 2'b11 writes nothing.
REQ-024 Timing from edge T: sdram_ack in cycle T+1; data_dst in cycle T+LATENCY; data_rdy in cycle T+LATENCY+1. Each is exactly one cycle wide; WAIT absorbs the remaining cycles.
REQ-025 data_read SHALL show the addressed word during the data_rdy cycle. On a write, that word is the post-write value. data_read holds its value until the next data_rdy.
REQ-026 After RDY the FSM SHALL return to IDLE. A request visible in that IDLE cycle is accepted there, so back-to-back requests are spaced LATENCY+2 cycles apart.
REQ-027 Requests still high during ACK/WAIT/DST/RDY (arbiter drop latency) SHALL be ignored, never double-accepted.
REQ-028 Addresses SHALL wrap modulo 2^AW; upper address bits are ignored.
REQ-029 Refresh counter: free-running, counts 0..REF_PERIOD-1 and wraps. At wrap it sets ref_pending. A second wrap while pending sets nothing extra.
REQ-030 In IDLE, ref_pending SHALL take priority over a simultaneous request. The FSM enters REF for REF_LEN cycles, clears ref_pending, then returns to IDLE. A request held meanwhile is acked after REF.
REQ-031 A refresh falling due during a transaction SHALL wait until that transaction's RDY.

Reset
REQ-032 While rst_n is low the block SHALL be in state IDLE with sdram_ack=0, data_dst=0, data_rdy=0, busy=0, data_read=16'h0, refresh counter=0 and ref_pending=0. This holds regardless of clock.
REQ-033 Reset asserted mid-transaction SHALL abort it with no data_rdy. A partially started write is not guaranteed.
REQ-034 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-035 Write then read, LATENCY=4: write addr 0x010, data 0xBEEF, mask 00, at T -> ack T+1, dst T+4, rdy T+5. Then read 0x010 -> data_read=0xBEEF at rdy.
REQ-036 Byte mask: word 0xBEEF, then write 0x1234 with mask 2'b10 -> read returns 0xBE34. Mask 2'b11 -> word unchanged.
REQ-037 Wrap, AW=12: write 0x5A5A to addr 0x1005 -> read of 0x005 returns 0x5A5A.
REQ-038 Held request: rd kept high until ack plus one cycle -> exactly one ack and one data_rdy. A next request issued on the rdy cycle is acked LATENCY+2 cycles after the previous ack.
REQ-039 Refresh, REF_PERIOD=20, REF_LEN=3: request coincides with due refresh in IDLE -> busy for 3 cycles, then ack. Refresh due mid-read -> read completes on time, REF follows.
REQ-040 Async reset: drop rst_n between ack and data_rdy -> outputs go to reset values immediately with no clock edge, no data_rdy. After release, a new read completes normally.
